// File: rtl/nand_share_arbiter.sv
// Round-robin arbiter that time-shares one transistor-level 2-input NAND cell
// among N_REQ requesters, holding the cell inputs for SETTLE cycles per operation.
module nand_share_arbiter #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] a_in,
  input  logic [N_REQ-1:0] b_in,
  output logic [N_REQ-1:0] gnt,
  output logic [N_REQ-1:0] done,
  output logic             y_out,
  output logic             cell_a,
  output logic             cell_b,
  input  logic             cell_y
);

  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CntW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(SETTLE - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(N_REQ - 1);

  typedef enum logic [1:0] {StIdle, StDrive, StCapture} state_e;

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic              y_q, y_d;
  logic              cell_a_q, cell_a_d;
  logic              cell_b_q, cell_b_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [N_REQ-1:0]  eligible;
  logic              found;
  logic [IdxW-1:0]   sel;
  logic [IdxW-1:0]   cand_idx;
  int unsigned       cand;

  // A requester whose done is currently high is masked so it cannot be
  // re-granted on the same edge it is being told its result is ready.
  always_comb begin
    eligible = req & ~done_q;
    found    = 1'b0;
    sel      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand     = (32'(ptr_q) + i) % N_REQ;
      cand_idx = IdxW'(cand);
      if (!found && eligible[cand_idx]) begin
        found = 1'b1;
        sel   = cand_idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    y_d      = y_q;
    cell_a_d = cell_a_q;
    cell_b_d = cell_b_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;

    case (state_q)
      StIdle: begin
        if (found) begin
          gnt_d    = {{(N_REQ-1){1'b0}}, 1'b1} << sel;
          cell_a_d = a_in[sel];
          cell_b_d = b_in[sel];
          idx_d    = sel;
          cnt_d    = '0;
          state_d  = StDrive;
        end
      end
      StDrive: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          state_d = StCapture;
        end
      end
      StCapture: begin
        y_d          = cell_y;
        done_d[idx_q] = 1'b1;
        gnt_d        = '0;
        ptr_d        = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
        state_d      = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      gnt_q    <= '0;
      done_q   <= '0;
      y_q      <= 1'b0;
      cell_a_q <= 1'b0;
      cell_b_q <= 1'b0;
      ptr_q    <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      y_q      <= y_d;
      cell_a_q <= cell_a_d;
      cell_b_q <= cell_b_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
    end
  end

  assign gnt    = gnt_q;
  assign done   = done_q;
  assign y_out  = y_q;
  assign cell_a = cell_a_q;
  assign cell_b = cell_b_q;

endmodule

// File: tb/tb_nand_share_arbiter.sv
// Directed bench for nand_share_arbiter: one DUT with SETTLE=2 and one with
// SETTLE=1, each with a behavioural NAND on cell_y.
module tb_nand_share_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req, a_in, b_in, gnt, done;
  logic       y_out, cell_a, cell_b, cell_y;
  logic [3:0] s1_req, s1_a, s1_b, s1_gnt, s1_done;
  logic       s1_y, s1_cell_a, s1_cell_b, s1_cell_y;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign cell_y    = ~(cell_a & cell_b);
  assign s1_cell_y = ~(s1_cell_a & s1_cell_b);

  nand_share_arbiter #(.N_REQ(4), .SETTLE(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .done(done), .y_out(y_out),
    .cell_a(cell_a), .cell_b(cell_b), .cell_y(cell_y)
  );

  nand_share_arbiter #(.N_REQ(4), .SETTLE(1)) u_dut_s1 (
    .clk(clk), .rst_n(rst_n), .req(s1_req), .a_in(s1_a), .b_in(s1_b),
    .gnt(s1_gnt), .done(s1_done), .y_out(s1_y),
    .cell_a(s1_cell_a), .cell_b(s1_cell_b), .cell_y(s1_cell_y)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after a rising edge; releases reset before the next edge.
  task automatic do_reset;
    rst_n  = 1'b0;
    req    = '0; a_in = '0; b_in = '0;
    s1_req = '0; s1_a = '0; s1_b = '0;
    #3;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n  = 1'b0;
    req    = 4'b1111; a_in = 4'b1111; b_in = 4'b1111;
    s1_req = 4'b1111; s1_a = 4'b1111; s1_b = 4'b1111;
    tick;
    n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL rst_gnt: got %b want 0000", gnt); end
    n_tests++; if (done !== 4'b0000) begin n_fail++; $display("FAIL rst_done: got %b want 0000", done); end
    n_tests++; if (y_out !== 1'b0) begin n_fail++; $display("FAIL rst_y: got %b want 0", y_out); end
    n_tests++; if (cell_a !== 1'b0) begin n_fail++; $display("FAIL rst_cell_a: got %b want 0", cell_a); end
    n_tests++; if (cell_b !== 1'b0) begin n_fail++; $display("FAIL rst_cell_b: got %b want 0", cell_b); end
    n_tests++; if (s1_gnt !== 4'b0000) begin n_fail++; $display("FAIL rst_s1_gnt: got %b want 0000", s1_gnt); end
    n_tests++; if (s1_done !== 4'b0000) begin n_fail++; $display("FAIL rst_s1_done: got %b want 0000", s1_done); end
    req = '0; a_in = '0; b_in = '0;
    s1_req = '0; s1_a = '0; s1_b = '0;
    #3;
    rst_n = 1'b1;
    tick;
    n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL rst_idle_gnt: got %b want 0000", gnt); end
  endtask

  task automatic test_single;
    do_reset;
    req = 4'b0001; a_in = 4'b0001; b_in = 4'b0001;
    tick; // edge 1
    n_tests++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL single_gnt: got %b want 0001", gnt); end
    n_tests++; if (done !== 4'b0000) begin n_fail++; $display("FAIL single_done_e1: got %b want 0000", done); end
    tick; // edge 2
    n_tests++; if (cell_a !== 1'b1 || cell_b !== 1'b1) begin n_fail++; $display("FAIL single_cell: got %b%b want 11", cell_a, cell_b); end
    tick; // edge 3
    n_tests++; if (done !== 4'b0000) begin n_fail++; $display("FAIL single_done_e3: got %b want 0000", done); end
    tick; // edge 4
    n_tests++; if (done !== 4'b0001) begin n_fail++; $display("FAIL single_done_e4: got %b want 0001", done); end
    n_tests++; if (y_out !== 1'b0) begin n_fail++; $display("FAIL single_y: got %b want 0", y_out); end
    n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL single_gnt_e4: got %b want 0000", gnt); end
    req = 4'b0000;
    tick; // edge 5
    n_tests++; if (done !== 4'b0000) begin n_fail++; $display("FAIL single_done_e5: got %b want 0000", done); end
    n_tests++; if (y_out !== 1'b0) begin n_fail++; $display("FAIL single_y_hold: got %b want 0", y_out); end
  endtask

  task automatic test_all_four;
    logic [3:0] exp_y;
    logic [3:0] exp_g;
    exp_y = 4'b1110;
    do_reset;
    req = 4'b1111; a_in = 4'b0101; b_in = 4'b0011;
    for (int op = 0; op < 4; op++) begin
      exp_g = 4'b0001 << op;
      tick; // grant edge, same edge as previous done falling
      n_tests++; if (gnt !== exp_g) begin n_fail++; $display("FAIL all4_gnt op%0d: got %b want %b", op, gnt, exp_g); end
      n_tests++; if (done !== 4'b0000) begin n_fail++; $display("FAIL all4_done_low op%0d: got %b want 0000", op, done); end
      tick; tick; tick;
      n_tests++; if (done !== exp_g) begin n_fail++; $display("FAIL all4_done op%0d: got %b want %b", op, done, exp_g); end
      n_tests++; if (y_out !== exp_y[op]) begin n_fail++; $display("FAIL all4_y op%0d: got %b want %b", op, y_out, exp_y[op]); end
      req[op] = 1'b0;
    end
    tick;
  endtask

  task automatic test_fairness;
    logic [3:0] exp_g;
    logic       exp_y;
    do_reset;
    req = 4'b0101; a_in = 4'b0101; b_in = 4'b0100;
    for (int op = 0; op < 4; op++) begin
      exp_g = (op % 2 == 0) ? 4'b0001 : 4'b0100;
      exp_y = (op % 2 == 0) ? 1'b1 : 1'b0;
      tick;
      n_tests++; if (gnt !== exp_g) begin n_fail++; $display("FAIL fair_gnt op%0d: got %b want %b", op, gnt, exp_g); end
      tick; tick; tick;
      n_tests++; if (done !== exp_g) begin n_fail++; $display("FAIL fair_done op%0d: got %b want %b", op, done, exp_g); end
      n_tests++; if (y_out !== exp_y) begin n_fail++; $display("FAIL fair_y op%0d: got %b want %b", op, y_out, exp_y); end
    end
    req = '0;
    tick;
  endtask

  task automatic test_operand_stability;
    do_reset;
    req = 4'b0010; a_in = 4'b0010; b_in = 4'b0010;
    tick; // grant
    n_tests++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL stab_gnt: got %b want 0010", gnt); end
    a_in[1] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick;
      n_tests++; if (cell_a !== 1'b1) begin n_fail++; $display("FAIL stab_cell_a c%0d: got %b want 1", c, cell_a); end
    end
    tick;
    n_tests++; if (done !== 4'b0010) begin n_fail++; $display("FAIL stab_done: got %b want 0010", done); end
    n_tests++; if (y_out !== 1'b0) begin n_fail++; $display("FAIL stab_y: got %b want 0", y_out); end
    req = '0;
    tick;
  endtask

  task automatic test_reset_mid_op;
    do_reset;
    req = 4'b0010; a_in = 4'b0000; b_in = 4'b0000;
    tick; tick; tick; tick;
    n_tests++; if (done !== 4'b0010 || y_out !== 1'b1) begin n_fail++; $display("FAIL rmid_pre: got done %b y %b want 0010 1", done, y_out); end
    req = 4'b1000; a_in = 4'b1001; b_in = 4'b1000;
    tick;
    n_tests++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL rmid_gnt3: got %b want 1000", gnt); end
    tick; // in DRIVE
    rst_n = 1'b0;
    #1;
    n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL rmid_gnt: got %b want 0000", gnt); end
    n_tests++; if (done !== 4'b0000) begin n_fail++; $display("FAIL rmid_done: got %b want 0000", done); end
    n_tests++; if (y_out !== 1'b0) begin n_fail++; $display("FAIL rmid_y: got %b want 0", y_out); end
    n_tests++; if (cell_a !== 1'b0 || cell_b !== 1'b0) begin n_fail++; $display("FAIL rmid_cell: got %b%b want 00", cell_a, cell_b); end
    req = 4'b1001;
    #2;
    rst_n = 1'b1;
    tick; // k: pointer restarts at 0
    n_tests++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL rmid_regnt: got %b want 0001", gnt); end
    for (int c = 0; c < 3; c++) begin
      n_tests++; if (done !== 4'b0000) begin n_fail++; $display("FAIL rmid_nodone c%0d: got %b want 0000", c, done); end
      tick;
    end
    n_tests++; if (done !== 4'b0001 || y_out !== 1'b1) begin n_fail++; $display("FAIL rmid_done0: got done %b y %b want 0001 1", done, y_out); end
    req = 4'b1000;
    tick;
    n_tests++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL rmid_gnt3b: got %b want 1000", gnt); end
    tick; tick; tick;
    n_tests++; if (done !== 4'b1000 || y_out !== 1'b0) begin n_fail++; $display("FAIL rmid_done3: got done %b y %b want 1000 0", done, y_out); end
    req = '0;
    tick;
  endtask

  task automatic test_settle1_truth;
    logic [3:0] exp_y;
    int unsigned pi;
    exp_y = 4'b0111;
    do_reset;
    for (int p = 0; p < 4; p++) begin
      pi = p;
      s1_a = '0; s1_a[3] = pi[1];
      s1_b = '0; s1_b[3] = pi[0];
      s1_req = 4'b1000;
      tick; // k
      n_tests++; if (s1_gnt !== 4'b1000) begin n_fail++; $display("FAIL s1_gnt p%0d: got %b want 1000", p, s1_gnt); end
      tick; // k+1
      n_tests++; if (s1_done !== 4'b0000) begin n_fail++; $display("FAIL s1_done_early p%0d: got %b want 0000", p, s1_done); end
      tick; // k+2
      n_tests++; if (s1_done !== 4'b1000) begin n_fail++; $display("FAIL s1_done p%0d: got %b want 1000", p, s1_done); end
      n_tests++; if (s1_y !== exp_y[p]) begin n_fail++; $display("FAIL s1_y p%0d: got %b want %b", p, s1_y, exp_y[p]); end
      s1_req = '0;
      tick;
      n_tests++; if (s1_done !== 4'b0000) begin n_fail++; $display("FAIL s1_done_pulse p%0d: got %b want 0000", p, s1_done); end
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_all_four;
    test_fairness;
    test_operand_stability;
    test_reset_mid_op;
    test_settle1_truth;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
